// File: rtl/fisr_processor.sv
// Fast inverse square root of a 7-digit BCD decimal entry: magic-constant seed
// plus one Newton-Raphson step, with a single shared float32 multiplier.
module fisr_processor (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  dot,
    input  logic        start_process,
    input  logic [3:0]  iDEC6,
    input  logic [3:0]  iDEC5,
    input  logic [3:0]  iDEC4,
    input  logic [3:0]  iDEC3,
    input  logic [3:0]  iDEC2,
    input  logic [3:0]  iDEC1,
    input  logic [3:0]  iDEC0,
    output logic [3:0]  oDEC7,
    output logic [3:0]  oDEC6,
    output logic [3:0]  oDEC5,
    output logic [3:0]  oDEC4,
    output logic [3:0]  oDEC3,
    output logic [3:0]  oDEC2,
    output logic [3:0]  oDEC1,
    output logic [3:0]  oDEC0,
    output logic        DONE,
    output logic        state,
    output logic [31:0] result_float32
);

    typedef enum logic [3:0] {
        S_IDLE, S_CONV, S_SCALE, S_MAGIC, S_SQ, S_HALF, S_SUB, S_NEWT, S_FIN
    } fsm_e;

    fsm_e        fsm_q, fsm_d;
    logic        prev_q;
    logic        start_go;
    logic [23:0] n_q, n_d;
    logic [1:0]  f_q, f_d;
    logic        zero_q, zero_d;
    logic [31:0] fn_q, fn_d, x_q, x_d, y0_q, y0_d, t_q, t_d;
    logic [31:0] p_q, p_d, q_q, q_d, y1_q, y1_d, result_q, result_d;
    logic        done_q, done_d;

    logic [3:0]  dig     [7];
    logic [3:0]  dig_val [7];
    logic        dot_hit;
    logic [1:0]  dot_pos;
    logic [6:0]  skip;
    logic [23:0] n_cap;

    assign dig[6] = iDEC6;
    assign dig[5] = iDEC5;
    assign dig[4] = iDEC4;
    assign dig[3] = iDEC3;
    assign dig[2] = iDEC2;
    assign dig[1] = iDEC1;
    assign dig[0] = iDEC0;

    // The point symbol (10) and codes 11-15 contribute a zero digit
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_digit
            assign dig_val[gi] = (dig[gi] <= 4'd9) ? dig[gi] : 4'd0;
        end
    endgenerate

    always_comb begin
        dot_hit = 1'b1;
        dot_pos = 2'd0;
        casez (dot)
            4'b???1: dot_pos = 2'd0;
            4'b??10: dot_pos = 2'd1;
            4'b?100: dot_pos = 2'd2;
            4'b1000: dot_pos = 2'd3;
            default: dot_hit = 1'b0;
        endcase
        skip  = dot_hit ? (7'd1 << dot_pos) : 7'd0;
        n_cap = '0;
        for (int i = 6; i >= 0; i--) begin
            if (!skip[i]) begin
                n_cap = 24'(n_cap * 24'd10 + {20'd0, dig_val[i]});
            end
        end
    end

    assign start_go = start_process & ~prev_q & (fsm_q == S_IDLE);

    // Integer to float32: exact because N always fits in the 24-bit significand
    logic [4:0]  lead;
    logic [31:0] fn_conv;
    always_comb begin
        lead = '0;
        for (int i = 0; i < 24; i++) begin
            if (n_q[i]) lead = 5'(i);
        end
        fn_conv = {1'b0, 8'd127 + {3'd0, lead}, 23'(n_q << (5'd23 - lead))};
    end

    logic [31:0] c_val;
    always_comb begin
        case (f_q)
            2'd0:    c_val = 32'h3F80_0000;
            2'd1:    c_val = 32'h3DCC_CCCD;
            2'd2:    c_val = 32'h3C23_D70A;
            default: c_val = 32'h3A83_126F;
        endcase
    end

    // Shared multiplier; operands are chosen by whichever state needs a product
    logic [31:0] mul_a, mul_b, mul_y;
    logic [47:0] mul_prod;
    logic        mul_ovf;
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (fsm_q)
            S_SCALE: begin mul_a = fn_q; mul_b = c_val; end
            S_SQ:    begin mul_a = y0_q; mul_b = y0_q;  end
            S_HALF:  begin mul_a = p_q;  mul_b = t_q;   end
            S_NEWT:  begin mul_a = y0_q; mul_b = q_q;   end
            default: ;
        endcase
        mul_prod = {24'd0, 1'b1, mul_a[22:0]} * {24'd0, 1'b1, mul_b[22:0]};
        mul_ovf  = mul_prod[47];
        mul_y    = {mul_a[31] ^ mul_b[31],
                    8'({2'b0, mul_a[30:23]} + {2'b0, mul_b[30:23]} + {9'd0, mul_ovf} - 10'd127),
                    23'(mul_prod >> (mul_ovf ? 6'd24 : 6'd23))};
    end

    // 1.5 - p in Q2.24 fixed point, then renormalise back to float32
    logic [23:0] p_m;
    logic [7:0]  p_e;
    logic [25:0] p_fix, q_fix;
    logic [4:0]  q_lead;
    logic [31:0] q_float;
    always_comb begin
        p_m   = {1'b1, p_q[22:0]};
        p_e   = p_q[30:23];
        p_fix = (p_e >= 8'd126) ? ({2'b0, p_m} << (p_e - 8'd126))
                                : ({2'b0, p_m} >> (8'd126 - p_e));
        q_fix = 26'h180_0000 - p_fix;
        q_lead = '0;
        for (int i = 0; i < 26; i++) begin
            if (q_fix[i]) q_lead = 5'(i);
        end
        q_float = (q_fix == '0) ? 32'd0
                : {1'b0, 8'd103 + {3'd0, q_lead}, 23'((q_fix << (5'd25 - q_lead)) >> 2)};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  if (start_go) fsm_d = S_CONV;
            S_CONV:  fsm_d = S_SCALE;
            S_SCALE: fsm_d = S_MAGIC;
            S_MAGIC: fsm_d = S_SQ;
            S_SQ:    fsm_d = S_HALF;
            S_HALF:  fsm_d = S_SUB;
            S_SUB:   fsm_d = S_NEWT;
            S_NEWT:  fsm_d = S_FIN;
            default: fsm_d = S_IDLE;
        endcase
    end

    always_comb begin
        state = (fsm_q != S_IDLE);
    end

    always_comb begin
        n_d      = n_q;
        f_d      = f_q;
        zero_d   = zero_q;
        fn_d     = fn_q;
        x_d      = x_q;
        y0_d     = y0_q;
        t_d      = t_q;
        p_d      = p_q;
        q_d      = q_q;
        y1_d     = y1_q;
        result_d = result_q;
        done_d   = done_q;
        case (fsm_q)
            S_IDLE: begin
                if (start_go) begin
                    n_d    = n_cap;
                    f_d    = dot_pos;
                    zero_d = (n_cap == '0);
                    done_d = 1'b0;
                end
            end
            S_CONV:  fn_d = fn_conv;
            S_SCALE: x_d  = mul_y;
            S_MAGIC: begin
                y0_d = 32'h5F37_59DF - (x_q >> 1);
                t_d  = {x_q[31], x_q[30:23] - 8'd1, x_q[22:0]};
            end
            S_SQ:    p_d  = mul_y;
            S_HALF:  p_d  = mul_y;
            S_SUB:   q_d  = q_float;
            S_NEWT:  y1_d = mul_y;
            S_FIN: begin
                result_d = zero_q ? 32'h7F80_0000 : y1_q;
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_q   <= 1'b0;
            n_q      <= '0;
            f_q      <= '0;
            zero_q   <= 1'b0;
            fn_q     <= '0;
            x_q      <= '0;
            y0_q     <= '0;
            t_q      <= '0;
            p_q      <= '0;
            q_q      <= '0;
            y1_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            prev_q   <= start_process;
            n_q      <= n_d;
            f_q      <= f_d;
            zero_q   <= zero_d;
            fn_q     <= fn_d;
            x_q      <= x_d;
            y0_q     <= y0_d;
            t_q      <= t_d;
            p_q      <= p_d;
            q_q      <= q_d;
            y1_q     <= y1_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign DONE           = done_q;
    assign result_float32 = result_q;
    assign oDEC7 = result_q[31:28];
    assign oDEC6 = result_q[27:24];
    assign oDEC5 = result_q[23:20];
    assign oDEC4 = result_q[19:16];
    assign oDEC3 = result_q[15:12];
    assign oDEC2 = result_q[11:8];
    assign oDEC1 = result_q[7:4];
    assign oDEC0 = result_q[3:0];

endmodule

// File: tb/tb_fisr_processor.sv
// Randomised and directed checks of fisr_processor against a real-arithmetic
// 1/sqrt(x) model, with a scoreboard queue drained by an independent monitor.
module tb_fisr_processor;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  dot = 4'd0;
    logic        start_process = 1'b0;
    logic [3:0]  iDEC6 = 0, iDEC5 = 0, iDEC4 = 0, iDEC3 = 0, iDEC2 = 0, iDEC1 = 0, iDEC0 = 0;
    logic [3:0]  oDEC7, oDEC6, oDEC5, oDEC4, oDEC3, oDEC2, oDEC1, oDEC0;
    logic        DONE, state;
    logic [31:0] result_float32;
    logic [31:0] odec_all;

    fisr_processor dut (
        .CLK(CLK), .RST(RST), .dot(dot), .start_process(start_process),
        .iDEC6(iDEC6), .iDEC5(iDEC5), .iDEC4(iDEC4), .iDEC3(iDEC3),
        .iDEC2(iDEC2), .iDEC1(iDEC1), .iDEC0(iDEC0),
        .oDEC7(oDEC7), .oDEC6(oDEC6), .oDEC5(oDEC5), .oDEC4(oDEC4),
        .oDEC3(oDEC3), .oDEC2(oDEC2), .oDEC1(oDEC1), .oDEC0(oDEC0),
        .DONE(DONE), .state(state), .result_float32(result_float32)
    );

    assign odec_all = {oDEC7, oDEC6, oDEC5, oDEC4, oDEC3, oDEC2, oDEC1, oDEC0};

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit  zero;
        real val;
        int  e0;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done_seen = 1'b0;

    task automatic chk_bits(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    task automatic chk_range(input string name, input real v, input real lo, input real hi);
        checks++;
        if (!(v >= lo && v <= hi)) begin
            errors++;
            $display("FAIL %s actual=%f required=[%f,%f]", name, v, lo, hi);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        real r;
        int  e;
        r = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        for (int i = 0; i < e; i++) r = r * 2.0;
        for (int i = 0; i > e; i--) r = r / 2.0;
        return b[31] ? -r : r;
    endfunction

    // Decimal value of the entry as the user reads it, then the ideal 1/sqrt
    function automatic real model(input logic [27:0] digs, input logic [3:0] dt, output bit is_zero);
        int         point;
        longint     n;
        logic [3:0] d;
        real        x;
        point = -1;
        n = 0;
        for (int k = 0; k < 4; k++) if (dt[k] && point < 0) point = k;
        for (int i = 6; i >= 0; i--) begin
            d = digs[i*4 +: 4];
            if (i != point) n = n * 10 + ((d <= 4'd9) ? longint'(d) : 0);
        end
        is_zero = (n == 0);
        x = real'(n);
        for (int k = 0; k < point; k++) x = x / 10.0;
        return is_zero ? 0.0 : 1.0 / $sqrt(x);
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        real  r;
        real  rel;
        if (DONE && !done_seen) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%08h required=no result", result_float32);
            end else begin
                e = sb_q.pop_front();
                chk_bits("latency", 32'(cyc - e.e0), 32'd8);
                chk_bits("odec_nibbles", odec_all, result_float32);
                if (e.zero) begin
                    chk_bits("zero_inf", result_float32, 32'h7F80_0000);
                    $display("txn e0=%0d result=%08h expected=+inf", e.e0, result_float32);
                end else begin
                    r   = f2r(result_float32);
                    rel = (r - e.val) / e.val;
                    chk_range("rel_error", rel, -0.0025, 0.0025);
                    $display("txn e0=%0d result=%08h (%g) expected=%g", e.e0, result_float32, r, e.val);
                end
            end
        end
        done_seen = DONE;
    end

    task automatic issue(input logic [27:0] digs, input logic [3:0] dt, input bit hold);
        exp_t e;
        bit   z;
        e.val  = model(digs, dt, z);
        e.zero = z;
        e.e0   = cyc + 1;
        {iDEC6, iDEC5, iDEC4, iDEC3, iDEC2, iDEC1, iDEC0} = digs;
        dot = dt;
        start_process = 1'b1;
        sb_q.push_back(e);
        @(posedge CLK); #1;
        if (!hold) start_process = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            @(posedge CLK); #1;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout actual=pending %0d required=0", sb_q.size());
            sb_q.delete();
        end
        @(posedge CLK); #1;
    endtask

    task automatic idle_outputs(input string name);
        chk_bits({name, "_done"},   {31'd0, DONE},  32'd0);
        chk_bits({name, "_state"},  {31'd0, state}, 32'd0);
        chk_bits({name, "_result"}, result_float32, 32'd0);
        chk_bits({name, "_odec"},   odec_all,       32'd0);
    endtask

    initial begin
        logic [27:0] digs;
        logic [3:0]  dt;
        int          r;

        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        idle_outputs("reset");
        repeat (3) @(posedge CLK);
        #1 idle_outputs("idle");

        // 123.456
        issue({4'd1, 4'd2, 4'd3, 4'd10, 4'd4, 4'd5, 4'd6}, 4'b1000, 1'b0);
        @(posedge CLK); #1;
        chk_bits("busy_state", {31'd0, state}, 32'd1);
        wait_done();
        chk_range("val_123_456", f2r(result_float32), 0.08982, 0.09018);
        chk_bits("nibbles_3DB", {20'd0, oDEC7, oDEC6, oDEC5}, 32'h3DB);
        chk_bits("after_state", {31'd0, state}, 32'd0);

        // 1.0
        issue({4'd0, 4'd0, 4'd1, 4'd10, 4'd0, 4'd0, 4'd0}, 4'b1000, 1'b0);
        wait_done();
        chk_range("val_1_0", f2r(result_float32), 0.998, 0.999);
        chk_bits("exp_1_0", {24'd0, result_float32[30:23]}, 32'd126);

        // 4, start held high across completion
        issue({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4}, 4'b0000, 1'b1);
        wait_done();
        chk_range("val_4", f2r(result_float32), 0.499, 0.5);
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            chk_bits("hold_state", {31'd0, state}, 32'd0);
        end
        chk_bits("hold_done", {31'd0, DONE}, 32'd1);
        start_process = 1'b0;
        @(posedge CLK); #1;

        // Reset sampled at E0+4
        issue({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd5}, 4'b0000, 1'b0);
        repeat (3) begin @(posedge CLK); #1; end
        RST = 1'b1;
        @(posedge CLK); #1;
        idle_outputs("midreset");
        sb_q.delete();
        RST = 1'b0;
        repeat (12) begin @(posedge CLK); #1; end
        chk_bits("no_done_after_reset", {31'd0, DONE}, 32'd0);

        // Zero input with a second start while busy
        issue(28'd0, 4'b0000, 1'b0);
        @(posedge CLK); #1 start_process = 1'b1;
        @(posedge CLK); #1 start_process = 1'b0;
        wait_done();
        chk_bits("zero_result", result_float32, 32'h7F80_0000);
        repeat (10) begin @(posedge CLK); #1; end
        chk_bits("no_restart_state", {31'd0, state}, 32'd0);
        chk_bits("no_restart_done", {31'd0, DONE}, 32'd1);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 7; i++) begin
                digs[i*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                              : 4'($urandom_range(0, 9));
            end
            r = $urandom_range(0, 5);
            if (r == 5)      dt = 4'($urandom_range(0, 15));
            else if (r == 4) dt = 4'd0;
            else             dt = 4'd1 << r;
            issue(digs, dt, 1'b0);
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
